replica_sequencer: RTL
======================

REPLICA_SEQUENCER -- requirements
Module: replica_sequencer

Interface
REQ-001 SHALL have parameter REPLICA_NUM, default 32, number of replicas driven.
REQ-002 SHALL have parameter OPT_CYCLES, default 6, length of the OPT phase in cycles.
REQ-003 SHALL have parameter DIST_CYCLES, default 21, length of the DIST phase in cycles.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 Ports, in order:
- clk  in  1  clock
- reset  in  1  async active-high reset
- set_command  in  1  write c_exchange into the table
- run_command  in  1  start an exchange/OPT step
- run_distance  in  1  start a DIST phase
- c_exchange  in  exchange_command_t  exchange command
- c_metropolis  in  exchange_command_t  metropolis command
- opt_com  in  opt_command_t[REPLICA_NUM]  per-replica opt request
- rbank  out  1  bank select
- busy  out  1  FSM not IDLE
- cmd_overflow  out  1  sticky table overflow
- run_ignored  out  1  sticky: run request dropped while busy
- c_exchange_out  out  exchange_command_t[REPLICA_NUM]  per-replica exchange
- c_metropolis_out  out  exchange_command_t[REPLICA_NUM]  per-replica metropolis
- opt_command  out  opt_command_t[REPLICA_NUM]  per-replica opt command
- c_distance  out  distance_command_t  distance micro-op

Function
REQ-006 FSM states SHALL be IDLE, OPT and DIST; busy = (state != IDLE).
REQ-007 In IDLE, run_command SHALL do all of the following: go to OPT, clear the step counter, toggle rbank, and load c_exchange_out for exactly one cycle.
REQ-008 If IDLE sees run_command and run_distance in the same cycle, run_command SHALL win and run_distance SHALL be dropped.
REQ-009 In IDLE, run_distance alone SHALL do all of the following: go to DIST, register opt_com into opt_command, clear the counter, and latch the distance mode.
REQ-010 OPT SHALL last OPT_CYCLES cycles, then return to IDLE with opt_command set to THR for every replica in that same edge.
REQ-011 DIST SHALL last DIST_CYCLES cycles, then return to IDLE with opt_command unchanged.
REQ-012 A run_command or run_distance that arrives while busy SHALL be ignored and SHALL set run_ignored.
REQ-013 In IDLE, random_run is not an input, so opt_command SHALL keep its value.
REQ-014 Exchange table: REPLICA_NUM entries plus a write pointer wptr.
- set_command (any state) SHALL write c_exchange at wptr and increment wptr.
- When wptr == REPLICA_NUM, the write SHALL be dropped and cmd_overflow set.
REQ-015 On an accepted run_command:
- c_exchange != NOP: c_exchange SHALL be broadcast to all c_exchange_out.
- c_exchange == NOP: table entry i SHALL go to c_exchange_out[i], all entries SHALL be cleared to NOP, and wptr SHALL reset to 0.
REQ-016 If set_command and an accepted run_command (NOP) occur in the same cycle, the table dump SHALL happen first and the new write SHALL land at entry 0 with wptr=1.
REQ-017 c_exchange_out SHALL be NOP in every cycle other than the one after an accepted run_command.
REQ-018 c_metropolis_out SHALL be combinational:
- PREV/SELF: broadcast c_metropolis.
- FOLW: per replica, c_exchange_out[i], with SELF replaced by NOP.
- Otherwise: NOP.
REQ-019 The distance mode SHALL come from the lowest-index opt_com entry that is not THR: OR0/OR1 -> OR0 mode, TWO -> TWO mode, none -> NONE.
REQ-020 c_distance SHALL be registered and indexed by the DIST counter k. Default {KN,DNOP}.
- OR0 mode, k=0..6: {KN,ZERO},{KM,MNS},{KP,PLS},{KN,MNS},{LN,PLS},{LP,MNS},{KN,PLS}.
- TWO mode, k=0..4: {KN,ZERO},{KM,MNS},{LM,PLS},{LN,MNS},{KN,PLS}.
- Outside DIST: {KN,DNOP}.

Reset
REQ-021 Reset SHALL put every output and register in this state: state=IDLE, rbank=0, wptr=0, table all NOP, c_exchange_out NOP, opt_command all THR, c_distance {KN,DNOP}, cmd_overflow=0, run_ignored=0.
REQ-022 Reset asserted mid-phase SHALL abort the phase immediately, with no residual outputs after release.

Configuration
REQ-023 With REPLICA_SEQ_CMD_TABLE_EN defined, the exchange table SHALL be built as in REQ-014..016.
REQ-024 Without REPLICA_SEQ_CMD_TABLE_EN:
- No table storage; set_command ignored; cmd_overflow tied 0.
- run_command with c_exchange == NOP SHALL drive NOP to all c_exchange_out.

Structure
REQ-025 replica_pkg SHALL hold the types and enumerations: exchange_command_t, opt_command_t, distance_command_t, the distance select and op encodings, and the FSM state enum.
REQ-026 The distance micro-op schedule SHALL be a sub-module, replica_dist_rom (inputs: mode, k; output: c_distance, combinational).

Verification
REQ-027 Reset: assert reset for 3 cycles, then release -> all outputs match REQ-021 and busy=0.
REQ-028 Table dump:
- Stimulus: set_command 3x with PREV,SELF,FOLW, then run_command with c_exchange=NOP.
- Response: next cycle c_exchange_out[0..2]=PREV,SELF,FOLW, the rest NOP; wptr=0.
- Then c_metropolis=FOLW gives c_metropolis_out[1]=NOP.
REQ-029 Overflow: with REPLICA_NUM=4, set_command 5x -> cmd_overflow=1, and the 5th value is absent from the dump.
REQ-030 Distance, OR0 mode:
- Stimulus: opt_com[2]=OR1, others THR; pulse run_distance.
- Response: c_distance follows the 7-step OR0 list, then DNOP; busy for 21 cycles; opt_command = opt_com.
REQ-031 Collision: run_command while in DIST -> run_ignored=1 and rbank unchanged. Simultaneous run_command + run_distance in IDLE -> OPT entered and rbank toggled.
REQ-032 Mid-phase reset: assert reset at DIST k=3 -> c_distance={KN,DNOP} and state=IDLE immediately.

Source files
------------

// File: rtl/replica_pkg.sv
// Shared types for the replica sequencer: command encodings, distance micro-op
// format, distance schedule modes and the sequencer FSM states.
package replica_pkg;

  typedef enum logic [1:0] {NOP, PREV, SELF, FOLW} exchange_command_t;

  typedef enum logic [1:0] {THR, OR0, OR1, TWO} opt_command_t;

  typedef enum logic [2:0] {KN, KM, KP, LN, LM, LP} dist_sel_t;

  typedef enum logic [1:0] {DNOP, ZERO, MNS, PLS} dist_op_t;

  typedef struct packed {
    dist_sel_t sel;
    dist_op_t  op;
  } distance_command_t;

  typedef enum logic [1:0] {MODE_NONE, MODE_OR0, MODE_TWO} dist_mode_t;

  typedef enum logic [1:0] {IDLE, OPT, DIST} state_t;

  localparam distance_command_t DIST_DEFAULT = '{sel: KN, op: DNOP};

endpackage

// File: rtl/replica_dist_rom.sv
// Combinational distance micro-op schedule, selected by mode and step index k.
module replica_dist_rom
  import replica_pkg::*;
#(
  parameter int KW = 5
) (
  input  dist_mode_t        mode,
  input  logic [KW-1:0]     k,
  output distance_command_t c_distance
);

  logic [31:0] idx;
  assign idx = 32'(k);

  always_comb begin
    c_distance = DIST_DEFAULT;
    case (mode)
      MODE_OR0: begin
        case (idx)
          32'd0:   c_distance = '{KN, ZERO};
          32'd1:   c_distance = '{KM, MNS};
          32'd2:   c_distance = '{KP, PLS};
          32'd3:   c_distance = '{KN, MNS};
          32'd4:   c_distance = '{LN, PLS};
          32'd5:   c_distance = '{LP, MNS};
          32'd6:   c_distance = '{KN, PLS};
          default: c_distance = DIST_DEFAULT;
        endcase
      end
      MODE_TWO: begin
        case (idx)
          32'd0:   c_distance = '{KN, ZERO};
          32'd1:   c_distance = '{KM, MNS};
          32'd2:   c_distance = '{LM, PLS};
          32'd3:   c_distance = '{LN, MNS};
          32'd4:   c_distance = '{KN, PLS};
          default: c_distance = DIST_DEFAULT;
        endcase
      end
      default: c_distance = DIST_DEFAULT;
    endcase
  end

endmodule

// File: rtl/replica_sequencer.sv
// Replica exchange/OPT/DIST sequencer. Define REPLICA_SEQ_CMD_TABLE_EN to build
// the per-replica exchange command table; otherwise only broadcast is supported.
module replica_sequencer
  import replica_pkg::*;
#(
  parameter int REPLICA_NUM = 32,
  parameter int OPT_CYCLES  = 6,
  parameter int DIST_CYCLES = 21
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_command,
  input  logic              run_command,
  input  logic              run_distance,
  input  exchange_command_t c_exchange,
  input  exchange_command_t c_metropolis,
  input  opt_command_t      opt_com          [REPLICA_NUM],
  output logic              rbank,
  output logic              busy,
  output logic              cmd_overflow,
  output logic              run_ignored,
  output exchange_command_t c_exchange_out   [REPLICA_NUM],
  output exchange_command_t c_metropolis_out [REPLICA_NUM],
  output opt_command_t      opt_command      [REPLICA_NUM],
  output distance_command_t c_distance
);

  localparam int MAX_CYC = (OPT_CYCLES > DIST_CYCLES) ? OPT_CYCLES : DIST_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] OPT_LAST  = CW'(OPT_CYCLES - 1);
  localparam logic [CW-1:0] DIST_LAST = CW'(DIST_CYCLES - 1);

  state_t            state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  dist_mode_t        mode, mode_d, scan_mode;
  logic              rbank_d, ign_d, run_ok, found;
  exchange_command_t xout_d [REPLICA_NUM];
  exchange_command_t dump   [REPLICA_NUM];
  opt_command_t      opt_d  [REPLICA_NUM];
  distance_command_t rom_out, dist_d;

  assign busy = (state != IDLE);

  // Lowest-index replica that is not THR decides the distance schedule.
  always_comb begin
    scan_mode = MODE_NONE;
    found     = 1'b0;
    for (int i = 0; i < REPLICA_NUM; i++) begin
      if (!found && opt_com[i] != THR) begin
        found     = 1'b1;
        scan_mode = (opt_com[i] == TWO) ? MODE_TWO : MODE_OR0;
      end
    end
  end

  // NOTE: every variable gets a default before the case so no latch is inferred;
  // combinational blocks use blocking '=' while the state register uses '<='.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    mode_d  = mode;
    rbank_d = rbank;
    ign_d   = run_ignored;
    opt_d   = opt_command;
    run_ok  = 1'b0;
    case (state)
      IDLE: begin
        if (run_command) begin
          run_ok  = 1'b1;
          state_d = OPT;
          cnt_d   = '0;
          rbank_d = ~rbank;
        end else if (run_distance) begin
          state_d = DIST;
          cnt_d   = '0;
          opt_d   = opt_com;
          mode_d  = scan_mode;
        end
      end
      OPT: begin
        ign_d = run_ignored | run_command | run_distance;
        if (cnt == OPT_LAST) begin
          state_d = IDLE;
          opt_d   = '{default: THR};
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DIST: begin
        ign_d = run_ignored | run_command | run_distance;
        if (cnt == DIST_LAST) state_d = IDLE;
        else                  cnt_d   = cnt + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    xout_d = '{default: NOP};
    if (run_ok) begin
      if (c_exchange != NOP) xout_d = '{default: c_exchange};
      else                   xout_d = dump;
    end
  end

  // Distance op is registered against the next counter value so it lines up
  // with the DIST cycle it belongs to.
  replica_dist_rom #(.KW(CW)) u_rom (
    .mode       (mode_d),
    .k          (cnt_d),
    .c_distance (rom_out)
  );

  assign dist_d = (state_d == DIST) ? rom_out : DIST_DEFAULT;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      mode           <= MODE_NONE;
      rbank          <= 1'b0;
      run_ignored    <= 1'b0;
      c_exchange_out <= '{default: NOP};
      opt_command    <= '{default: THR};
      c_distance     <= DIST_DEFAULT;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      mode           <= mode_d;
      rbank          <= rbank_d;
      run_ignored    <= ign_d;
      c_exchange_out <= xout_d;
      opt_command    <= opt_d;
      c_distance     <= dist_d;
    end
  end

  always_comb begin
    c_metropolis_out = '{default: NOP};
    case (c_metropolis)
      PREV, SELF: c_metropolis_out = '{default: c_metropolis};
      FOLW: begin
        for (int i = 0; i < REPLICA_NUM; i++)
          c_metropolis_out[i] = (c_exchange_out[i] == SELF) ? NOP : c_exchange_out[i];
      end
      default: c_metropolis_out = '{default: NOP};
    endcase
  end

`ifdef REPLICA_SEQ_CMD_TABLE_EN
  localparam int PW = $clog2(REPLICA_NUM + 1);

  exchange_command_t tbl   [REPLICA_NUM];
  exchange_command_t tbl_d [REPLICA_NUM];
  logic [PW-1:0]     wptr, wptr_d;
  logic              ovf_d;

  // A dump clears the table before any same-cycle write lands.
  always_comb begin
    tbl_d  = tbl;
    wptr_d = wptr;
    ovf_d  = cmd_overflow;
    if (run_ok && c_exchange == NOP) begin
      tbl_d  = '{default: NOP};
      wptr_d = '0;
    end
    if (set_command) begin
      if (wptr_d == PW'(REPLICA_NUM)) begin
        ovf_d = 1'b1;
      end else begin
        for (int i = 0; i < REPLICA_NUM; i++)
          if (PW'(i) == wptr_d) tbl_d[i] = c_exchange;
        wptr_d = wptr_d + 1'b1;
      end
    end
  end

  // NOTE: the table is small and must read NOP after reset, so it is reset
  // like ordinary flops rather than inferred as RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tbl          <= '{default: NOP};
      wptr         <= '0;
      cmd_overflow <= 1'b0;
    end else begin
      tbl          <= tbl_d;
      wptr         <= wptr_d;
      cmd_overflow <= ovf_d;
    end
  end

  assign dump = tbl;
`else
  logic unused_set;
  assign unused_set   = set_command;
  assign dump         = '{default: NOP};
  assign cmd_overflow = 1'b0;
`endif

endmodule
